// File: rtl/couchand_byte_alu.sv
// couchand_byte_alu: byte-wide registered ALU (A, B, R, carry, zero) for a Tiny Tapeout tile.
// Optional macro ACC_WRITEBACK_EN: every execute also writes its result back into A.
module couchand_byte_alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [7:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic       c_q, c_d, z_q, z_d;
    logic [1:0] cmd;
    logic [3:0] op;
    logic [8:0] res;
    logic       unused;

    assign cmd     = uio_in[5:4];
    assign op      = uio_in[3:0];
    assign unused  = &{1'b0, uio_in[7:6]};
    assign uo_out  = r_q;
    assign uio_out = {c_q, z_q, 6'd0};
    assign uio_oe  = 8'b1100_0000;

    // Opcode decode: bit 8 is the new carry, bits 7:0 the new result; subtraction borrow falls out of bit 8.
    always_comb begin
        res = {1'b0, b_q};
        case (op)
            4'h0: res = {1'b0, a_q} + {1'b0, b_q};
            4'h1: res = {1'b0, a_q} + {1'b0, b_q} + {8'd0, c_q};
            4'h2: res = {1'b0, a_q} - {1'b0, b_q};
            4'h3: res = {1'b0, a_q} - {1'b0, b_q} - {8'd0, c_q};
            4'h4: res = {1'b0, a_q & b_q};
            4'h5: res = {1'b0, a_q | b_q};
            4'h6: res = {1'b0, a_q ^ b_q};
            4'h7: res = {1'b0, ~a_q};
            4'h8: res = {a_q[7], a_q[6:0], 1'b0};
            4'h9: res = {a_q[0], 1'b0, a_q[7:1]};
            4'ha: res = {a_q[0], a_q[7], a_q[7:1]};
            4'hb: res = {a_q[7], a_q[6:0], a_q[7]};
            4'hc: res = {a_q[0], a_q[0], a_q[7:1]};
            4'hd: res = {1'b0, a_q} + 9'd1;
            4'he: res = {1'b0, a_q} - 9'd1;
            default: res = {1'b0, b_q};
        endcase
    end

    // Command handling: loads touch only their operand, execute updates R and both flags.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        r_d = r_q;
        c_d = c_q;
        z_d = z_q;
        if (ena) begin
            a_d = (cmd == 2'b01) ? ui_in : a_q;
            b_d = (cmd == 2'b10) ? ui_in : b_q;
            if (cmd == 2'b11) begin
                r_d = res[7:0];
                c_d = res[8];
                z_d = (res[7:0] == 8'd0);
`ifdef ACC_WRITEBACK_EN
                a_d = res[7:0];
`else
                a_d = a_q;
`endif
            end
        end
    end

    // State registers; the harness-named rst_n is an active-high asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_q <= 8'd0;
            b_q <= 8'd0;
            r_q <= 8'd0;
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
            c_q <= c_d;
            z_q <= z_d;
        end
    end
endmodule

// File: tb/tb_couchand_byte_alu.sv
// tb_couchand_byte_alu: vector table, hand sequences and randomized model check for couchand_byte_alu.
module tb_couchand_byte_alu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out, uio_out, uio_oe;
    int checks = 0;
    int errors = 0;
    int ma, mb, mr, mc, mz;

    typedef struct {
        bit en;
        int cmd;
        int op;
        int d;
        int r;
        int c;
        int z;
    } vec_t;
    vec_t v[$];

    couchand_byte_alu dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input bit e, input int cmd, input int op, input int d);
        ena = e;
        uio_in = {2'($urandom), 2'(cmd), 4'(op)};
        ui_in = 8'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int r, input int c, input int z);
        chk({nm, " R"}, uo_out, 8'(r));
        chk({nm, " flags"}, uio_out, {1'(c), 1'(z), 6'd0});
    endtask

    // Reference model in plain integer arithmetic.
    task automatic model(input bit e, input int cmd, input int op, input int d);
        int s;
        int r;
        int c;
        if (!e) return;
        if (cmd == 1) ma = d;
        if (cmd == 2) mb = d;
        if (cmd != 3) return;
        c = 0;
        case (op)
            0: begin s = ma + mb; r = s % 256; c = int'(s > 255); end
            1: begin s = ma + mb + mc; r = s % 256; c = int'(s > 255); end
            2: begin s = ma - mb; r = (s + 512) % 256; c = int'(s < 0); end
            3: begin s = ma - mb - mc; r = (s + 512) % 256; c = int'(s < 0); end
            4: r = ma & mb;
            5: r = ma | mb;
            6: r = ma ^ mb;
            7: r = 255 - ma;
            8: begin r = (ma * 2) % 256; c = ma / 128; end
            9: begin r = ma / 2; c = ma % 2; end
            10: begin r = ma / 2 + (ma >= 128 ? 128 : 0); c = ma % 2; end
            11: begin r = (ma * 2) % 256 + ma / 128; c = ma / 128; end
            12: begin r = ma / 2 + (ma % 2) * 128; c = ma % 2; end
            13: begin r = (ma + 1) % 256; c = int'(ma == 255); end
            14: begin r = (ma + 255) % 256; c = int'(ma == 0); end
            default: r = mb;
        endcase
        mr = r;
        mc = c;
        mz = int'(r == 0);
`ifdef ACC_WRITEBACK_EN
        ma = r;
`endif
    endtask

    initial begin
        #2 rst_n = 1'b1;
        #1;
        chk("reset uo_out", uo_out, 8'h00);
        chk("reset uio_out", uio_out, 8'h00);
        chk("reset uio_oe", uio_oe, 8'hC0);
        @(posedge clk);
        #1 rst_n = 1'b0;

        v.push_back('{1, 1, 0, 'hF0, 'h00, 0, 0});
        v.push_back('{1, 2, 0, 'h20, 'h00, 0, 0});
        v.push_back('{1, 3, 0, 'h00, 'h10, 1, 0});
        v.push_back('{1, 1, 0, 'hF0, 'h10, 1, 0});
        v.push_back('{1, 3, 1, 'h00, 'h11, 1, 0});
        v.push_back('{1, 1, 0, 'h05, 'h11, 1, 0});
        v.push_back('{1, 2, 0, 'h05, 'h11, 1, 0});
        v.push_back('{1, 3, 2, 'h00, 'h00, 0, 1});
        v.push_back('{1, 1, 0, 'h03, 'h00, 0, 1});
        v.push_back('{1, 3, 2, 'h00, 'hFE, 1, 0});
        v.push_back('{1, 1, 0, 'h81, 'hFE, 1, 0});
        v.push_back('{1, 3, 8, 'h00, 'h02, 1, 0});
        v.push_back('{1, 1, 0, 'h81, 'h02, 1, 0});
        v.push_back('{1, 3, 10, 'h00, 'hC0, 1, 0});
        v.push_back('{1, 1, 0, 'h81, 'hC0, 1, 0});
        v.push_back('{1, 3, 11, 'h00, 'h03, 1, 0});
        v.push_back('{1, 1, 0, 'h81, 'h03, 1, 0});
        v.push_back('{1, 3, 12, 'h00, 'hC0, 1, 0});
        v.push_back('{0, 1, 0, 'h55, 'hC0, 1, 0});
        v.push_back('{0, 3, 15, 'h00, 'hC0, 1, 0});
        v.push_back('{1, 1, 0, 'h55, 'hC0, 1, 0});
        v.push_back('{1, 3, 15, 'h00, 'h05, 0, 0});
        v.push_back('{1, 2, 0, 'h00, 'h05, 0, 0});
        v.push_back('{1, 3, 15, 'h00, 'h00, 0, 1});
        v.push_back('{1, 1, 0, 'h00, 'h00, 0, 1});
        v.push_back('{1, 3, 14, 'h00, 'hFF, 1, 0});
        v.push_back('{1, 1, 0, 'hFF, 'hFF, 1, 0});
        v.push_back('{1, 3, 13, 'h00, 'h00, 1, 1});
        v.push_back('{1, 1, 0, 'h0F, 'h00, 1, 1});
        v.push_back('{1, 2, 0, 'hF0, 'h00, 1, 1});
        v.push_back('{1, 3, 4, 'h00, 'h00, 0, 1});
        v.push_back('{1, 1, 0, 'h0F, 'h00, 0, 1});
        v.push_back('{1, 3, 6, 'h00, 'hFF, 0, 0});
        v.push_back('{1, 1, 0, 'h3C, 'hFF, 0, 0});
        v.push_back('{1, 3, 7, 'h00, 'hC3, 0, 0});
        v.push_back('{1, 1, 0, 'h00, 'hC3, 0, 0});
        v.push_back('{1, 3, 14, 'h00, 'hFF, 1, 0});
        v.push_back('{1, 1, 0, 'h10, 'hFF, 1, 0});
        v.push_back('{1, 2, 0, 'h0F, 'hFF, 1, 0});
        v.push_back('{1, 3, 3, 'h00, 'h00, 0, 1});
        v.push_back('{1, 1, 0, 'h40, 'h00, 0, 1});
        v.push_back('{1, 3, 5, 'h00, 'h4F, 0, 0});
        v.push_back('{1, 1, 0, 'h40, 'h4F, 0, 0});
        v.push_back('{1, 3, 9, 'h00, 'h20, 0, 0});
        foreach (v[i]) begin
            step(v[i].en, v[i].cmd, v[i].op, v[i].d);
            expect_out($sformatf("vec%0d", i), v[i].r, v[i].c, v[i].z);
        end

        step(1, 1, 0, 'h01);
        for (int k = 0; k < 3; k++) begin
            step(1, 3, 13, 0);
`ifdef ACC_WRITEBACK_EN
            expect_out($sformatf("wb inc%0d", k), 2 + k, 0, 0);
`else
            expect_out($sformatf("wb inc%0d", k), 2, 0, 0);
`endif
        end

        #3 rst_n = 1'b1;
        #1;
        chk("midreset uo_out", uo_out, 8'h00);
        chk("midreset uio_out", uio_out, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b0;
        step(1, 3, 15, 0);
        expect_out("post reset pass", 0, 0, 1);

        ma = 0; mb = 0; mr = 0; mc = 0; mz = 1;
        for (int i = 0; i < 3000; i++) begin
            bit e;
            int cmd, op, d;
            e = ($urandom_range(0, 7) != 0);
            cmd = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 255));
            step(e, cmd, op, d);
            model(e, cmd, op, d);
            expect_out($sformatf("rand%0d op%0d", i, op), mr, mc, mz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
